// File: rtl/vtc_param_if.sv
// Video timing controller bus: runtime config handshake plus timing outputs.
// slave = the timing controller, master = the config/consumer side.
interface vtc_param_if #(
    parameter int CNT_W = 12
);
    // run control and shadow config
    logic             enable;
    logic [CNT_W-1:0] cfg_h_sync;
    logic [CNT_W-1:0] cfg_h_bp;
    logic [CNT_W-1:0] cfg_h_active;
    logic [CNT_W-1:0] cfg_h_fp;
    logic [CNT_W-1:0] cfg_v_sync;
    logic [CNT_W-1:0] cfg_v_bp;
    logic [CNT_W-1:0] cfg_v_active;
    logic [CNT_W-1:0] cfg_v_fp;
    logic             cfg_load;
    logic             cfg_pending;
    logic             cfg_err;

    // timing outputs
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x_pos;
    logic [CNT_W-1:0] y_pos;
    logic             line_start;
    logic             frame_start;

    modport master (
        output enable,
        output cfg_h_sync, cfg_h_bp, cfg_h_active, cfg_h_fp,
        output cfg_v_sync, cfg_v_bp, cfg_v_active, cfg_v_fp,
        output cfg_load,
        input  cfg_pending, cfg_err,
        input  hsync, vsync, de, x_pos, y_pos,
        input  line_start, frame_start
    );

    modport slave (
        input  enable,
        input  cfg_h_sync, cfg_h_bp, cfg_h_active, cfg_h_fp,
        input  cfg_v_sync, cfg_v_bp, cfg_v_active, cfg_v_fp,
        input  cfg_load,
        output cfg_pending, cfg_err,
        output hsync, vsync, de, x_pos, y_pos,
        output line_start, frame_start
    );
endinterface

// File: rtl/vtc_param.sv
// Parametrised video timing controller with frame-boundary shadow config.
// Ports: clock_in (pixel clk), reset (async, active-low), bus (vtc_param_if.slave).
module vtc_param #(
    parameter int CNT_W    = 12,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clock_in,
    input  logic       reset,
    vtc_param_if.slave bus
);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t hs;
        cnt_t hb;
        cnt_t ha;
        cnt_t hf;
        cnt_t vs;
        cnt_t vb;
        cnt_t va;
        cnt_t vf;
    } tim_t;

    localparam tim_t TIM_RST = '{
        hs: cnt_t'(H_SYNC), hb: cnt_t'(H_BP),
        ha: cnt_t'(H_ACTIVE), hf: cnt_t'(H_FP),
        vs: cnt_t'(V_SYNC), vb: cnt_t'(V_BP),
        va: cnt_t'(V_ACTIVE), vf: cnt_t'(V_FP)
    };

    localparam int SW = CNT_W + 2;

    // state
    tim_t tim_q, tim_d;
    tim_t pend_tim_q, pend_tim_d;
    logic pend_q, pend_d;
    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;

    // registered outputs
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    cnt_t x_pos_q, x_pos_d;
    cnt_t y_pos_q, y_pos_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
    logic cfg_err_q, cfg_err_d;

    // incoming config and its validation
    tim_t           cfg_in;
    logic [SW-1:0]  h_sum;
    logic [SW-1:0]  v_sum;
    logic           cfg_ok;

    assign cfg_in = '{
        hs: bus.cfg_h_sync, hb: bus.cfg_h_bp,
        ha: bus.cfg_h_active, hf: bus.cfg_h_fp,
        vs: bus.cfg_v_sync, vb: bus.cfg_v_bp,
        va: bus.cfg_v_active, vf: bus.cfg_v_fp
    };

    // sums carry two extra bits so overflow of the totals is visible
    assign h_sum = SW'(cfg_in.hs) + SW'(cfg_in.hb)
                 + SW'(cfg_in.ha) + SW'(cfg_in.hf);
    assign v_sum = SW'(cfg_in.vs) + SW'(cfg_in.vb)
                 + SW'(cfg_in.va) + SW'(cfg_in.vf);

    assign cfg_ok = (cfg_in.hs != '0) && (cfg_in.hb != '0)
                 && (cfg_in.ha != '0) && (cfg_in.hf != '0)
                 && (cfg_in.vs != '0) && (cfg_in.vb != '0)
                 && (cfg_in.va != '0) && (cfg_in.vf != '0)
                 && (h_sum[SW-1:CNT_W] == 2'b00)
                 && (v_sum[SW-1:CNT_W] == 2'b00);

    // working timing decode (totals cannot overflow: validated on load)
    cnt_t h_tot, v_tot;
    cnt_t h_lo, h_hi, v_lo, v_hi;
    logic h_last, v_last, wrap;
    logic h_act, v_act;

    assign h_tot  = tim_q.hs + tim_q.hb + tim_q.ha + tim_q.hf;
    assign v_tot  = tim_q.vs + tim_q.vb + tim_q.va + tim_q.vf;
    assign h_lo   = tim_q.hs + tim_q.hb;
    assign h_hi   = h_lo + tim_q.ha;
    assign v_lo   = tim_q.vs + tim_q.vb;
    assign v_hi   = v_lo + tim_q.va;
    assign h_last = (h_cnt_q == h_tot - cnt_t'(1));
    assign v_last = (v_cnt_q == v_tot - cnt_t'(1));
    assign wrap   = h_last && v_last;
    assign h_act  = (h_cnt_q >= h_lo) && (h_cnt_q < h_hi);
    assign v_act  = (v_cnt_q >= v_lo) && (v_cnt_q < v_hi);

    always_comb begin
        tim_d         = tim_q;
        pend_tim_d    = pend_tim_q;
        pend_d        = pend_q;
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        de_d          = 1'b0;
        x_pos_d       = '0;
        y_pos_d       = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        cfg_err_d     = 1'b0;

        if (bus.enable) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + cnt_t'(1);
            v_cnt_d = v_cnt_q;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + cnt_t'(1);
            end

            // pending set is swapped in exactly as the counters hit (0,0)
            if (wrap && pend_q) begin
                tim_d  = pend_tim_q;
                pend_d = 1'b0;
            end

            hsync_d       = (h_cnt_q < tim_q.hs) ? HS_POL : ~HS_POL;
            vsync_d       = (v_cnt_q < tim_q.vs) ? VS_POL : ~VS_POL;
            de_d          = h_act && v_act;
            x_pos_d       = (h_act && v_act) ? h_cnt_q - h_lo : '0;
            y_pos_d       = v_act ? v_cnt_q - v_lo : '0;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end

        // a load on the wrap cycle lands in pending after the old set moved out
        if (bus.cfg_load) begin
            if (cfg_ok) begin
                pend_tim_d = cfg_in;
                pend_d     = 1'b1;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            tim_q         <= TIM_RST;
            pend_tim_q    <= '0;
            pend_q        <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            tim_q         <= tim_d;
            pend_tim_q    <= pend_tim_d;
            pend_q        <= pend_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.x_pos       = x_pos_q;
    assign bus.y_pos       = y_pos_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.cfg_pending = pend_q;
    assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vtc_param.sv
// Self-checking bench for vtc_param: per-cycle scoreboard against a
// behavioural timing model, plus frame-level checks on strobes and de counts.
module tb_vtc_param;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vtc_param_if #(.CNT_W(W)) vif ();

    vtc_param #(
        .CNT_W(W),
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clock_in(clk),
        .reset(rst_n),
        .bus(vif)
    );

    // {pend, err, hs, vs, de, x[7:0], y[7:0], ls, fs}
    localparam logic [22:0] RSTV = {2'b00, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00};

    int checks = 0;
    int failures = 0;

    // model state
    int mh, mv;
    int wc[8];
    int pc[8];
    bit mp;
    logic [22:0] exp_q[$];

    // frame-level tracking from observed outputs
    int ocyc = 0;
    int first_de = -1;
    logic [15:0] first_xy = '0;
    int de_cnt = 0;
    logic [15:0] last_xy = '0;
    int fs_q[$];
    int dec_q[$];
    logic [15:0] xy_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [22:0] pack_obs();
        return {vif.cfg_pending, vif.cfg_err, vif.hsync, vif.vsync, vif.de,
                vif.x_pos, vif.y_pos, vif.line_start, vif.frame_start};
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        wc = '{2, 1, 4, 1, 1, 1, 3, 1};
        pc = '{0, 0, 0, 0, 0, 0, 0, 0};
        mp = 1'b0;
    endtask

    function automatic bit at_last();
        return (mh == wc[0] + wc[1] + wc[2] + wc[3] - 1)
            && (mv == wc[4] + wc[5] + wc[6] + wc[7] - 1);
    endfunction

    // predicts the outputs the next clock edge will register
    task automatic model_edge();
        int hb, vb, htot, vtot;
        bit hact, vact, wrap, ok;
        int nc[8];
        logic hs, vs, de, ls, fs, err;
        logic [7:0] x, y;
        hs = 1'b1; vs = 1'b1; de = 1'b0; ls = 1'b0; fs = 1'b0;
        err = 1'b0; x = '0; y = '0; wrap = 1'b0;
        if (vif.enable) begin
            hb = wc[0] + wc[1];
            vb = wc[4] + wc[5];
            hact = (mh >= hb) && (mh < hb + wc[2]);
            vact = (mv >= vb) && (mv < vb + wc[6]);
            hs = !(mh < wc[0]);
            vs = !(mv < wc[4]);
            de = hact && vact;
            if (de) x = 8'(mh - hb);
            if (vact) y = 8'(mv - vb);
            ls = (mh == 0);
            fs = (mh == 0) && (mv == 0);
            htot = wc[0] + wc[1] + wc[2] + wc[3];
            vtot = wc[4] + wc[5] + wc[6] + wc[7];
            mh++;
            if (mh == htot) begin
                mh = 0;
                mv++;
                if (mv == vtot) begin
                    mv = 0;
                    wrap = 1'b1;
                end
            end
            if (wrap && mp) begin
                wc = pc;
                mp = 1'b0;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
        if (vif.cfg_load) begin
            nc = '{int'(vif.cfg_h_sync), int'(vif.cfg_h_bp),
                   int'(vif.cfg_h_active), int'(vif.cfg_h_fp),
                   int'(vif.cfg_v_sync), int'(vif.cfg_v_bp),
                   int'(vif.cfg_v_active), int'(vif.cfg_v_fp)};
            ok = 1'b1;
            foreach (nc[i]) if (nc[i] == 0) ok = 1'b0;
            if (nc[0] + nc[1] + nc[2] + nc[3] > 255) ok = 1'b0;
            if (nc[4] + nc[5] + nc[6] + nc[7] > 255) ok = 1'b0;
            if (ok) begin
                pc = nc;
                mp = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        exp_q.push_back({mp, err, hs, vs, de, x, y, ls, fs});
    endtask

    task automatic step();
        logic [22:0] o, e;
        model_edge();
        @(posedge clk);
        #1;
        o = pack_obs();
        e = exp_q.pop_front();
        chk("out", 32'(o), 32'(e));
        if (vif.enable) ocyc++;
        else ocyc = 0;
        if (o[0]) begin
            fs_q.push_back(ocyc);
            dec_q.push_back(de_cnt);
            xy_q.push_back(last_xy);
            de_cnt = 0;
        end
        if (o[18]) begin
            de_cnt++;
            last_xy = o[17:2];
            if (first_de < 0) begin
                first_de = ocyc;
                first_xy = o[17:2];
            end
        end
        vif.cfg_load = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int hs, input int hb, input int ha, input int hf,
                        input int vs, input int vb, input int va, input int vf);
        vif.cfg_h_sync   = W'(hs);
        vif.cfg_h_bp     = W'(hb);
        vif.cfg_h_active = W'(ha);
        vif.cfg_h_fp     = W'(hf);
        vif.cfg_v_sync   = W'(vs);
        vif.cfg_v_bp     = W'(vb);
        vif.cfg_v_active = W'(va);
        vif.cfg_v_fp     = W'(vf);
        vif.cfg_load     = 1'b1;
    endtask

    task automatic run_until_fs(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            step();
            if (vif.frame_start) seen++;
        end
        chk("fs_seen", seen, n);
    endtask

    task automatic clear_track();
        fs_q.delete();
        dec_q.delete();
        xy_q.delete();
    endtask

    initial begin
        vif.enable = 1'b0;
        vif.cfg_load = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        vif.cfg_load = 1'b0;
        model_reset();

        // reset state
        #12;
        chk("rst", 32'(pack_obs()), 32'(RSTV));
        rst_n = 1'b1;
        vif.enable = 1'b1;

        // basic timing over three default frames
        steps(100);
        chk("fs0", fs_q[0], 1);
        chk("fs1", fs_q[1], 49);
        chk("fs2", fs_q[2], 97);
        chk("first_de", first_de, 20);
        chk("first_xy", 32'(first_xy), 32'h0000);
        chk("de_cnt_f1", dec_q[1], 12);
        chk("last_xy_f1", 32'(xy_q[1]), 32'h0302);

        // mid-frame reconfig to H_ACTIVE=2
        clear_track();
        steps(10);
        load(2, 1, 2, 1, 1, 1, 3, 1);
        step();
        chk("pend_set", vif.cfg_pending, 1);
        run_until_fs(2, 200);
        chk("de_cnt_old", dec_q[0], 12);
        chk("de_cnt_new", dec_q[1], 6);
        chk("frame_len_new", fs_q[1] - fs_q[0], 36);

        // rejection keeps pending, then a second valid load wins
        clear_track();
        steps(5);
        load(2, 1, 3, 1, 1, 1, 3, 1);
        step();
        steps(2);
        load(2, 1, 4, 1, 1, 1, 0, 1);
        step();
        chk("err_pulse", vif.cfg_err, 1);
        chk("err_pend", vif.cfg_pending, 1);
        step();
        chk("err_clr", vif.cfg_err, 0);
        load(2, 1, 1, 1, 1, 1, 3, 1);
        step();
        run_until_fs(2, 200);
        chk("de_cnt_last", dec_q[1], 3);
        chk("frame_len_last", fs_q[1] - fs_q[0], 30);

        // load coincident with the wrap while another config pends
        clear_track();
        steps(3);
        load(2, 1, 4, 1, 1, 1, 3, 1);
        step();
        for (int k = 0; k < 200 && !at_last(); k++) step();
        chk("coll_sync", 32'(at_last()), 1);
        load(2, 1, 2, 1, 1, 1, 3, 1);
        step();
        chk("coll_pend", vif.cfg_pending, 1);
        run_until_fs(3, 300);
        chk("coll_de_old", dec_q[1], 12);
        chk("coll_de_new", dec_q[2], 6);
        chk("coll_pend_clr", vif.cfg_pending, 0);

        // enable drop mid-line and re-enable
        steps(3);
        vif.enable = 1'b0;
        step();
        chk("idle", 32'(pack_obs()), 32'(RSTV));
        steps(3);
        vif.enable = 1'b1;
        step();
        chk("reen_fs", vif.frame_start, 1);
        chk("reen_hs", vif.hsync, 0);

        // async reset mid-frame discards a pending config
        steps(5);
        load(2, 1, 2, 1, 1, 1, 3, 1);
        step();
        steps(7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst", 32'(pack_obs()), 32'(RSTV));
        model_reset();
        ocyc = 0;
        @(posedge clk);
        #1;
        chk("arst_hold", 32'(pack_obs()), 32'(RSTV));
        @(negedge clk);
        rst_n = 1'b1;
        clear_track();
        run_until_fs(3, 200);
        chk("arst_fs", fs_q[2], 97);
        chk("arst_de_f1", dec_q[1], 12);
        chk("arst_de_f2", dec_q[2], 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
